// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-channel reset release sequencer; optional ack handshake via RSTSEQ_ACK_EN
`timescale 1ns/1ps
module reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sw_rst,
  output logic [CHANNELS-1:0] o_rst_n,
  output logic                o_busy,
  output logic                o_done
`ifdef RSTSEQ_ACK_EN
  ,
  input  logic [CHANNELS-1:0] i_ack,
  output logic                o_timeout
`endif
);

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_GAP,
    ST_REL,
`ifdef RSTSEQ_ACK_EN
    ST_WAIT_ACK,
`endif
    ST_DONE
  } state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [CHANNELS-1:0]    rst_n_d;
  logic                   busy_d, done_d;
  logic                   sync_drop;
  logic                   last_ch;

`ifdef RSTSEQ_ACK_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  logic [TO_W-1:0] tcnt, tcnt_d;
  logic            timeout_d;
  logic            to_hit;
  logic            ack_ok;
  // an ack for the current channel, or running out of patience, both end the wait
  assign to_hit = (tcnt == TO_LAST) && !i_ack[idx];
  assign ack_ok = i_ack[idx] || (tcnt == TO_LAST);
`endif

  // the chain output is about to fall on this edge: leave SYNC together with it
  assign sync_drop = sync_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-2];
  assign last_ch   = (idx == IDX_LAST);

  // deassertion synchroniser: forced high asynchronously, shifts zeros in after release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_SYNC;
    else       state <= state_d;
  end

  // next-state decode; a soft reset restarts from the gap without re-running the synchroniser
  always_comb begin
    state_d = state;
    if (i_sw_rst) begin
      state_d = ST_GAP;
    end else begin
      case (state)
        ST_SYNC: if (sync_drop) state_d = ST_GAP;
        ST_GAP:  if (cnt == GAP_LAST) state_d = ST_REL;
`ifdef RSTSEQ_ACK_EN
        ST_REL:      state_d = ST_WAIT_ACK;
        ST_WAIT_ACK: if (ack_ok) state_d = last_ch ? ST_DONE : ST_GAP;
`else
        ST_REL:  state_d = last_ch ? ST_DONE : ST_GAP;
`endif
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_SYNC;
      endcase
    end
  end

  // next values of counters and outputs; outputs themselves are always flop-driven
  always_comb begin
    idx_d   = idx;
    cnt_d   = '0;
    rst_n_d = o_rst_n;
    busy_d  = o_busy;
    done_d  = o_done;
`ifdef RSTSEQ_ACK_EN
    tcnt_d    = '0;
    timeout_d = o_timeout;
`endif
    if (i_sw_rst) begin
      idx_d   = '0;
      rst_n_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      case (state)
        ST_GAP: if (cnt != GAP_LAST) cnt_d = cnt + 1'b1;
        ST_REL: begin
          rst_n_d[idx] = 1'b1;
`ifndef RSTSEQ_ACK_EN
          if (last_ch) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            idx_d = idx + 1'b1;
          end
`endif
        end
`ifdef RSTSEQ_ACK_EN
        ST_WAIT_ACK: begin
          if (ack_ok) begin
            if (to_hit) timeout_d = 1'b1;
            if (last_ch) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              idx_d = idx + 1'b1;
            end
          end else begin
            tcnt_d = tcnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // counters and registered outputs; the async reset asserts every channel at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx     <= '0;
      cnt     <= '0;
      o_rst_n <= '0;
      o_busy  <= 1'b1;
      o_done  <= 1'b0;
`ifdef RSTSEQ_ACK_EN
      tcnt      <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      idx     <= idx_d;
      cnt     <= cnt_d;
      o_rst_n <= rst_n_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
`ifdef RSTSEQ_ACK_EN
      tcnt      <= tcnt_d;
      o_timeout <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int C   = 4;
  localparam int S   = 2;
  localparam int G   = 4;
  localparam int GP  = (G > 0) ? G : 1;
  localparam int GP0 = 1;
`ifdef RSTSEQ_ACK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         sw_rst = 1'b0;
  logic [C-1:0] rst_n, rst_n0;
  logic         busy, done, busy0, done0;
`ifdef RSTSEQ_ACK_EN
  logic [C-1:0] ack = '1;
  logic         timeout, timeout0;
`endif

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int base   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.CHANNELS(C), .SYNC_STAGES(S), .GAP_CYCLES(G), .ACK_TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_rst(sw_rst),
    .o_rst_n(rst_n), .o_busy(busy), .o_done(done)
`ifdef RSTSEQ_ACK_EN
    , .i_ack(ack), .o_timeout(timeout)
`endif
  );

  reset_sequencer #(.CHANNELS(C), .SYNC_STAGES(S), .GAP_CYCLES(0), .ACK_TIMEOUT(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_sw_rst(sw_rst),
    .o_rst_n(rst_n0), .o_busy(busy0), .o_done(done0)
`ifdef RSTSEQ_ACK_EN
    , .i_ack(ack), .o_timeout(timeout0)
`endif
  );

  // reference: channel k is released (k+1) gap+release periods after the sequence base edge
  function automatic logic [C-1:0] exp_mask(int gp, int e);
    logic [C-1:0] m;
    m = '0;
    if (!rst)
      for (int k = 0; k < C; k++)
        if (e >= base + (k + 1) * (gp + 1) + k * EXTRA) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic exp_done(int gp, int e);
    return !rst && (e >= base + C * (gp + 1) + C * EXTRA);
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (sw_rst && !rst) base = edge_n;
    @(negedge clk);
  endtask

  task automatic release_rst();
    rst  = 1'b0;
    base = edge_n + S;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw_rst = 1'b0;
    repeat (3) tick();
    checks++; if (rst_n !== '0) begin errors++; $display("FAIL reset_rst_n got=%b exp=0000", rst_n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rst_n0 !== '0) begin errors++; $display("FAIL reset_rst_n0 got=%b exp=0000", rst_n0); end
`ifdef RSTSEQ_ACK_EN
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
`endif
  endtask

  task automatic test_power_on();
    int rel_e[4] = '{7, 12, 17, 22};
    int rel0_e[4] = '{4, 6, 8, 10};
    int t0;
    int rel;
    logic [C-1:0] m;
    release_rst();
    t0 = edge_n;
    for (int i = 0; i < 24 + C * EXTRA; i++) begin
      tick();
      rel = edge_n - t0;
      checks++; if (rst_n !== exp_mask(GP, edge_n)) begin errors++; $display("FAIL pwr_rst_n rel=%0d got=%b exp=%b", rel, rst_n, exp_mask(GP, edge_n)); end
      checks++; if (done !== exp_done(GP, edge_n) || busy !== !exp_done(GP, edge_n)) begin errors++; $display("FAIL pwr_done rel=%0d got=%b/%b exp done=%b", rel, done, busy, exp_done(GP, edge_n)); end
      checks++; if (rst_n0 !== exp_mask(GP0, edge_n)) begin errors++; $display("FAIL gap0_rst_n rel=%0d got=%b exp=%b", rel, rst_n0, exp_mask(GP0, edge_n)); end
      checks++; if (done0 !== exp_done(GP0, edge_n)) begin errors++; $display("FAIL gap0_done rel=%0d got=%b exp=%b", rel, done0, exp_done(GP0, edge_n)); end
      for (int k = 0; k < C; k++) begin
        m = C'((1 << (k + 1)) - 1);
        if (rel == rel_e[k] + k * EXTRA) begin
          checks++; if (rst_n !== m) begin errors++; $display("FAIL pwr_table rel=%0d got=%b exp=%b", rel, rst_n, m); end
        end
        if (rel == rel_e[k] + k * EXTRA - 1) begin
          checks++; if (rst_n !== (m >> 1)) begin errors++; $display("FAIL pwr_table_pre rel=%0d got=%b exp=%b", rel, rst_n, m >> 1); end
        end
        if (rel == rel0_e[k] + k * EXTRA) begin
          checks++; if (rst_n0 !== m) begin errors++; $display("FAIL gap0_table rel=%0d got=%b exp=%b", rel, rst_n0, m); end
        end
      end
      if (rel == 22 + C * EXTRA) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pwr_done_edge rel=%0d got=%b exp=1", rel, done); end
      end
    end
  endtask

  task automatic test_async_assert();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (rst_n !== '0) begin errors++; $display("FAIL async_rst_n got=%b exp=0000", rst_n); end
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL async_flags got done=%b busy=%b exp 0/1", done, busy); end
    @(negedge clk);
    release_rst();
    repeat (10) tick();
    #1 rst = 1'b1;
    #1;
    checks++; if (rst_n !== '0) begin errors++; $display("FAIL short_pulse_rst_n got=%b exp=0000", rst_n); end
    rst = 1'b0;
    base = edge_n + S;
    for (int i = 0; i < 24 + C * EXTRA; i++) begin
      tick();
      checks++; if (rst_n !== exp_mask(GP, edge_n) || done !== exp_done(GP, edge_n)) begin errors++; $display("FAIL short_pulse_seq e=%0d got=%b/%b exp=%b/%b", edge_n, rst_n, done, exp_mask(GP, edge_n), exp_done(GP, edge_n)); end
    end
  endtask

  task automatic test_sw_rst();
    rst = 1'b1;
    tick();
    release_rst();
    repeat (12 + EXTRA) tick();
    checks++; if (rst_n !== 4'b0011) begin errors++; $display("FAIL sw_pre got=%b exp=0011", rst_n); end
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    checks++; if (rst_n !== '0 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sw_clear got=%b done=%b busy=%b exp=0000/0/1", rst_n, done, busy); end
    for (int i = 1; i <= 24 + C * EXTRA; i++) begin
      tick();
      if (i == 4) begin
        checks++; if (rst_n !== 4'b0000) begin errors++; $display("FAIL sw_edge4 got=%b exp=0000", rst_n); end
      end
      if (i == 5) begin
        checks++; if (rst_n !== 4'b0001) begin errors++; $display("FAIL sw_edge5 got=%b exp=0001", rst_n); end
      end
      checks++; if (rst_n !== exp_mask(GP, edge_n) || done !== exp_done(GP, edge_n)) begin errors++; $display("FAIL sw_seq e=%0d got=%b/%b exp=%b/%b", edge_n, rst_n, done, exp_mask(GP, edge_n), exp_done(GP, edge_n)); end
    end
    checks++; if (done !== 1'b1 || rst_n !== '1) begin errors++; $display("FAIL sw_final got=%b done=%b exp=1111/1", rst_n, done); end
  endtask

  task automatic test_both();
    rst = 1'b1;
    sw_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rst_n !== '0 || busy !== 1'b1) begin errors++; $display("FAIL both_held got=%b busy=%b exp=0000/1", rst_n, busy); end
    end
    sw_rst = 1'b0;
    tick();
    release_rst();
    for (int i = 1; i <= 22 + C * EXTRA; i++) begin
      tick();
      checks++; if (rst_n !== exp_mask(GP, edge_n) || done !== exp_done(GP, edge_n)) begin errors++; $display("FAIL both_seq rel=%0d got=%b/%b exp=%b/%b", i, rst_n, done, exp_mask(GP, edge_n), exp_done(GP, edge_n)); end
    end
    checks++; if (done !== 1'b1 || rst_n !== '1) begin errors++; $display("FAIL both_final got=%b done=%b exp=1111/1", rst_n, done); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        sw_rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (rst_n !== '0 || done !== 1'b0) begin errors++; $display("FAIL rand_async got=%b done=%b exp=0000/0", rst_n, done); end
        rst = 1'b0;
        base = edge_n + S;
      end else begin
        sw_rst = (r < 9);
      end
      tick();
      checks++; if (rst_n !== exp_mask(GP, edge_n)) begin errors++; $display("FAIL rand_rst_n e=%0d got=%b exp=%b", edge_n, rst_n, exp_mask(GP, edge_n)); end
      checks++; if (done !== exp_done(GP, edge_n) || busy !== !exp_done(GP, edge_n)) begin errors++; $display("FAIL rand_flags e=%0d got=%b/%b exp done=%b", edge_n, done, busy, exp_done(GP, edge_n)); end
    end
    sw_rst = 1'b0;
  endtask

`ifdef RSTSEQ_ACK_EN
  task automatic test_ack_timeout();
    int t0;
    int rel;
    int e2;
    rst = 1'b1;
    tick();
    ack = 4'b1011;
    release_rst();
    t0 = edge_n;
    e2 = S + 3 * (GP + 1) + 2;
    for (int i = 0; i < e2 + 8 + GP + 4; i++) begin
      tick();
      rel = edge_n - t0;
      checks++; if (timeout !== (rel >= e2 + 8)) begin errors++; $display("FAIL ack_timeout rel=%0d got=%b exp=%b", rel, timeout, rel >= e2 + 8); end
      checks++; if (rst_n[2] !== (rel >= e2)) begin errors++; $display("FAIL ack_ch2 rel=%0d got=%b exp=%b", rel, rst_n[2], rel >= e2); end
      checks++; if (rst_n[3] !== (rel >= e2 + 8 + GP + 1)) begin errors++; $display("FAIL ack_ch3 rel=%0d got=%b exp=%b", rel, rst_n[3], rel >= e2 + 8 + GP + 1); end
      checks++; if (done !== (rel >= e2 + 8 + GP + 2)) begin errors++; $display("FAIL ack_done rel=%0d got=%b exp=%b", rel, done, rel >= e2 + 8 + GP + 2); end
    end
    ack = '1;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_power_on();
    test_async_assert();
    test_sw_rst();
    test_both();
    test_random();
`ifdef RSTSEQ_ACK_EN
    test_ack_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
